// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 stream transmitter and its receiver counterpart.
package rs232_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/rs232_bit_timer.sv
// Drift-free bit timer: bit k ends at floor((k*CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE) cycles after start.
// tick is high in the last cycle of each bit, so registered outputs change exactly on the boundary.
module rs232_bit_timer #(
    parameter int CLOCK_FREQ = 133000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic tick
);

    localparam int Q  = CLOCK_FREQ / BAUD_RATE;
    localparam int R  = CLOCK_FREQ % BAUD_RATE;
    localparam int CW = $clog2(Q + 1);
    localparam int RW = $clog2(BAUD_RATE) + 1;

    localparam logic [CW-1:0] LAST_SHORT = CW'(Q - 1);
    localparam logic [CW-1:0] LAST_LONG  = CW'(Q);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [RW-1:0] REM_INC    = RW'(R);
    localparam logic [RW-1:0] REM_MOD    = RW'(BAUD_RATE);
    localparam logic [RW-1:0] REM_INIT   = RW'(BAUD_RATE / 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [RW-1:0] rem_sum;
    logic          carry;

    // A bit lasts Q cycles, plus one whenever the fractional remainder overflows.
    always_comb begin
        rem_sum = rem_q + REM_INC;
        carry   = (rem_sum >= REM_MOD);
        tick    = (cnt_q == (carry ? LAST_LONG : LAST_SHORT));
        cnt_d   = cnt_q + CNT_ONE;
        rem_d   = rem_q;
        if (start) begin
            cnt_d = '0;
            rem_d = REM_INIT;
        end else if (tick) begin
            cnt_d = '0;
            rem_d = carry ? (rem_sum - REM_MOD) : rem_sum;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            rem_q <= REM_INIT;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/rs232_send_stream.sv
// Stream-to-RS232 transmitter: valid/ready byte input, LSB-first framing with optional
// parity and 1-2 stop bits, gated by the host's active-low RTS.
module rs232_send_stream
    import rs232_pkg::*;
#(
    parameter int CLOCK_FREQ = 133000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       iready,
    output logic       busy,
    output logic       rxd_pin,
    input  logic       rtsn_pin
);

    localparam int FRAME = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam int CNT_W = $clog2(FRAME);

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic             PAR_INV   = (PARITY == PARITY_ODD);
    localparam logic             HAS_PAR   = (PARITY != PARITY_NONE);

    frame_state_t         state_q, state_d;
    logic                 rts_meta_q, rts_sync_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic                 rxd_q, rxd_d;
    logic                 tick;
    logic                 accept;
    logic                 unused_idata;

    // Bits of idata above DATA_BITS are intentionally ignored.
    assign unused_idata = ^idata;
    assign accept       = ivalid && iready;
    assign rxd_pin      = rxd_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rts_meta_q <= 1'b1;
            rts_sync_q <= 1'b1;
        end else begin
            rts_meta_q <= rtsn_pin;
            rts_sync_q <= rts_meta_q;
        end
    end

    rs232_bit_timer #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .start(accept),
        .tick (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_START;
            ST_START:  if (tick) state_d = ST_DATA;
            ST_DATA:   if (tick && bit_cnt_q == DATA_LAST) state_d = HAS_PAR ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP:   if (tick && bit_cnt_q == STOP_LAST) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        iready = (state_q == ST_IDLE) && !rts_sync_q && !reset;
        busy   = (state_q != ST_IDLE);
    end

    // Line level for the bit that starts at the next boundary.
    always_comb begin
        case (state_d)
            ST_START:  rxd_d = 1'b0;
            ST_DATA:   rxd_d = shift_q[0];
            ST_PARITY: rxd_d = par_q;
            default:   rxd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rxd_q     <= 1'b1;
            bit_cnt_q <= '0;
        end else begin
            if (state_q == ST_IDLE || tick) rxd_q <= rxd_d;
            if (state_d != state_q) begin
                bit_cnt_q <= '0;
            end else if (tick && busy) begin
                bit_cnt_q <= bit_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            shift_q <= idata[DATA_BITS-1:0];
            par_q   <= (^idata[DATA_BITS-1:0]) ^ PAR_INV;
        end else if (tick && state_d == ST_DATA) begin
            shift_q <= shift_q >> 1;
        end
    end

endmodule

// File: tb/tb_rs232_send_stream.sv
// Bench for rs232_send_stream: four parameterisations on one clock, each frame compared
// bit by bit against line levels and boundaries computed from the framing rules.
`timescale 1ns/1ps
module tb_rs232_send_stream;

    localparam int NI = 4;
    localparam int CF [NI] = '{1000, 1000, 1000, 1000};
    localparam int BR [NI] = '{300, 100, 300, 250};
    localparam int DB [NI] = '{8, 8, 5, 8};
    localparam int PA [NI] = '{2, 0, 1, 1};
    localparam int SB [NI] = '{2, 1, 1, 2};

    logic          clk;
    logic [NI-1:0] rst;
    logic [NI-1:0] ivalid;
    logic [NI-1:0] rtsn;
    logic [7:0]    idata [NI];
    logic [NI-1:0] iready;
    logic [NI-1:0] busy;
    logic [NI-1:0] rxd;

    int n_checks = 0;
    int n_fail   = 0;

    rs232_send_stream #(.CLOCK_FREQ(1000), .BAUD_RATE(300), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u0 (
        .clock(clk), .reset(rst[0]), .idata(idata[0]), .ivalid(ivalid[0]), .iready(iready[0]),
        .busy(busy[0]), .rxd_pin(rxd[0]), .rtsn_pin(rtsn[0]));
    rs232_send_stream #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u1 (
        .clock(clk), .reset(rst[1]), .idata(idata[1]), .ivalid(ivalid[1]), .iready(iready[1]),
        .busy(busy[1]), .rxd_pin(rxd[1]), .rtsn_pin(rtsn[1]));
    rs232_send_stream #(.CLOCK_FREQ(1000), .BAUD_RATE(300), .DATA_BITS(5), .PARITY(1), .STOP_BITS(1)) u2 (
        .clock(clk), .reset(rst[2]), .idata(idata[2]), .ivalid(ivalid[2]), .iready(iready[2]),
        .busy(busy[2]), .rxd_pin(rxd[2]), .rtsn_pin(rtsn[2]));
    rs232_send_stream #(.CLOCK_FREQ(1000), .BAUD_RATE(250), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u3 (
        .clock(clk), .reset(rst[3]), .idata(idata[3]), .ivalid(ivalid[3]), .iready(iready[3]),
        .busy(busy[3]), .rxd_pin(rxd[3]), .rtsn_pin(rtsn[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion before 1000000 ns");
        $fatal(1, "watchdog expired");
    end

    // Reference model: bit boundary k of instance i, in cycles after the start bit begins.
    function automatic int bnd(input int i, input int k);
        return (k * CF[i] + BR[i] / 2) / BR[i];
    endfunction

    function automatic int nframe(input int i);
        return 1 + DB[i] + ((PA[i] != 0) ? 1 : 0) + SB[i];
    endfunction

    function automatic logic exp_bit(input int i, input logic [7:0] b, input int k);
        int ones;
        ones = 0;
        for (int j = 0; j < DB[i]; j++) ones += int'(b[j]);
        if (k == 0) return 1'b0;
        if (k <= DB[i]) return b[k-1];
        if (PA[i] != 0 && k == DB[i] + 1) return (PA[i] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
        return 1'b1;
    endfunction

    // Starts at a falling edge with the instance idle; returns at the falling edge of cycle B(FRAME)
    // with ivalid still high. rts_at >= 0 raises rtsn_pin during that cycle of the frame.
    task automatic run_frame(input int i, input logic [7:0] b, input int rts_at, input string tag);
        int   f;
        int   c;
        logic expv;
        logic obs;
        f = nframe(i);
        n_checks++;
        if (iready[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: iready=%b required 1", tag, iready[i]);
        end
        idata[i]  = b;
        ivalid[i] = 1'b1;
        @(posedge clk);
        #1;
        idata[i] = 8'($urandom);
        c = 0;
        for (int k = 0; k < f; k++) begin
            expv = exp_bit(i, b, k);
            obs  = expv;
            while (c < bnd(i, k + 1)) begin
                @(negedge clk);
                if (rxd[i] !== expv && obs === expv) obs = rxd[i];
                if (c == 0) begin
                    n_checks++;
                    if (busy[i] !== 1'b1 || iready[i] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s frame_start: busy=%b iready=%b required busy=1 iready=0",
                                 tag, busy[i], iready[i]);
                    end
                end
                if (c == rts_at) rtsn[i] = 1'b1;
                c++;
            end
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL %s bit%0d (cycles %0d..%0d): rxd=%b required %b",
                         tag, k, bnd(i, k), bnd(i, k + 1) - 1, obs, expv);
            end
        end
        @(negedge clk);
        n_checks++;
        if (rxd[i] !== 1'b1 || busy[i] !== 1'b0 || iready[i] !== (rts_at < 0)) begin
            n_fail++;
            $display("FAIL %s frame_end cycle %0d: rxd=%b busy=%b iready=%b required rxd=1 busy=0 iready=%b",
                     tag, f, rxd[i], busy[i], iready[i], (rts_at < 0));
        end
    endtask

    task automatic test_reset();
        rst    = '1;
        ivalid = '0;
        rtsn   = '0;
        for (int i = 0; i < NI; i++) idata[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (rxd[i] !== 1'b1 || busy[i] !== 1'b0 || iready[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state u%0d: rxd=%b busy=%b iready=%b required 1 0 0",
                         i, rxd[i], busy[i], iready[i]);
            end
        end
        rst = '0;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (iready[i] !== (n == 2)) begin
                    n_fail++;
                    $display("FAIL reset_release u%0d cycle %0d: iready=%b required %b",
                             i, n, iready[i], (n == 2));
                end
            end
            if (n < 2) @(negedge clk);
        end
    endtask

    task automatic test_basic();
        run_frame(1, 8'hA5, -1, "basic_a5");
        ivalid[1] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            repeat (2) @(negedge clk);
            run_frame(1, 8'($urandom), -1, "basic_rand");
            ivalid[1] = 1'b0;
        end
    endtask

    task automatic test_even_parity_two_stop();
        run_frame(0, 8'hA5, -1, "even_a5");
        ivalid[0] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            run_frame(0, 8'($urandom), -1, "even_rand");
            ivalid[0] = 1'b0;
        end
    endtask

    task automatic test_odd_parity();
        run_frame(3, 8'hA5, -1, "odd_a5");
        ivalid[3] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            run_frame(3, 8'($urandom), -1, "odd_rand");
            ivalid[3] = 1'b0;
        end
    endtask

    task automatic test_five_bits();
        run_frame(2, 8'hFF, -1, "five_ff");
        ivalid[2] = 1'b0;
        @(negedge clk);
        run_frame(2, 8'hE0, -1, "five_e0");
        ivalid[2] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            run_frame(2, 8'($urandom), -1, "five_rand");
            ivalid[2] = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b3;
        logic       obs_rxd;
        logic       obs_rdy;
        b3 = 8'($urandom);
        run_frame(0, 8'($urandom), -1, "b2b_1");
        run_frame(0, 8'($urandom), 12, "b2b_2");
        idata[0] = b3;
        obs_rxd  = 1'b1;
        obs_rdy  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rxd[0] !== 1'b1 && obs_rxd === 1'b1) obs_rxd = rxd[0];
            if (iready[0] !== 1'b0 && obs_rdy === 1'b0) obs_rdy = iready[0];
        end
        n_checks++;
        if (obs_rxd !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_hold_rxd: rxd=%b required 1 while rts deasserted", obs_rxd);
        end
        n_checks++;
        if (obs_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_hold_iready: iready=%b required 0 while rts deasserted", obs_rdy);
        end
        rtsn[0] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            n_checks++;
            if (iready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_rts_latency cycle %0d: iready=%b required 0", n, iready[0]);
            end
            @(negedge clk);
        end
        run_frame(0, b3, -1, "b2b_3");
        ivalid[0] = 1'b0;
    endtask

    task automatic test_reset_midframe();
        n_checks++;
        if (iready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_accept: iready=%b required 1", iready[1]);
        end
        idata[1]  = 8'h00;
        ivalid[1] = 1'b1;
        @(posedge clk);
        #1;
        ivalid[1] = 1'b0;
        repeat (26) @(negedge clk);
        n_checks++;
        if (rxd[1] !== 1'b0 || busy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_data: rxd=%b busy=%b required 0 1", rxd[1], busy[1]);
        end
        rst[1] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rxd[1] !== 1'b1 || busy[1] !== 1'b0 || iready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_after: rxd=%b busy=%b iready=%b required 1 0 0", rxd[1], busy[1], iready[1]);
        end
        rst[1] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (iready[1] !== 1'b0 || rxd[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_release1: iready=%b rxd=%b required 0 1", iready[1], rxd[1]);
        end
        @(negedge clk);
        n_checks++;
        if (iready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_release2: iready=%b required 1", iready[1]);
        end
        run_frame(1, 8'($urandom), -1, "midrst_next");
        ivalid[1] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_even_parity_two_stop();
        test_odd_parity();
        test_five_bits();
        test_back_to_back();
        test_reset_midframe();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
